// File: rtl/queen_board_checker_if.sv
// Row bus between the 8-queen solver output and the board checker, plus the checker's result/status lines.
interface queen_board_checker_if #(
    parameter int COUNT_WIDTH = 7
);
    logic                   row_valid;
    logic [7:0]             in_bus;
    logic                   row_ready;
    logic                   busy;
    logic                   done;
    logic                   legal;
    logic                   onehot_error;
    logic                   clear_count;
    logic [COUNT_WIDTH-1:0] solution_count;

    modport master (
        output row_valid, in_bus, clear_count,
        input  row_ready, busy, done, legal, onehot_error, solution_count
    );

    modport slave (
        input  row_valid, in_bus, clear_count,
        output row_ready, busy, done, legal, onehot_error, solution_count
    );
endinterface

// File: rtl/queen_board_checker.sv
// Captures eight one-hot rows, then checks the 28 queen pairs one per cycle; result pulses 1..29 cycles after row 7.
// Backpressure: row_ready is high only while receiving; rows offered during check/done are dropped.
module queen_board_checker #(
    parameter int COUNT_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    queen_board_checker_if.slave  bus
);
    typedef enum logic [1:0] {RECV, CHECK, DONE} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             rows_q [8];
    logic [7:0]             rows_d [8];
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             pi_q, pi_d;
    logic [2:0]             pj_q, pj_d;
    logic                   row_ready_q, row_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   legal_q, legal_d;
    logic                   onehot_error_q, onehot_error_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic       all_onehot;
    logic       conflict;
    logic       count_inc;
    logic [2:0] col_i, col_j;
    logic [3:0] diff_row, diff_col;

    function automatic logic [2:0] col_of(input logic [7:0] r);
        logic [2:0] c;
        c = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (r[k]) c = 3'(k);
        end
        return c;
    endfunction

    function automatic logic is_onehot(input logic [7:0] r);
        return (r != 8'd0) && ((r & (r - 8'd1)) == 8'd0);
    endfunction

    // Rows 0..6 are already stored when row 7 arrives, so row 7 is judged straight off the bus.
    always_comb begin
        all_onehot = is_onehot(bus.in_bus);
        for (int k = 0; k < 7; k++) begin
            if (!is_onehot(rows_q[k])) all_onehot = 1'b0;
        end
    end

    // Widened to 4 bits so the diagonal distance never wraps.
    assign col_i    = col_of(rows_q[pi_q]);
    assign col_j    = col_of(rows_q[pj_q]);
    assign diff_row = {1'b0, pi_q} - {1'b0, pj_q};
    assign diff_col = (col_i >= col_j) ? ({1'b0, col_i} - {1'b0, col_j})
                                       : ({1'b0, col_j} - {1'b0, col_i});
    assign conflict = (col_i == col_j) || (diff_row == diff_col);

    always_comb begin
        state_d        = state_q;
        rows_d         = rows_q;
        idx_d          = idx_q;
        pi_d           = pi_q;
        pj_d           = pj_q;
        row_ready_d    = row_ready_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        legal_d        = 1'b0;
        onehot_error_d = 1'b0;
        count_inc      = 1'b0;

        case (state_q)
            RECV: begin
                if (bus.row_valid) begin
                    rows_d[idx_q] = bus.in_bus;
                    idx_d         = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        row_ready_d = 1'b0;
                        if (all_onehot) begin
                            state_d = CHECK;
                            busy_d  = 1'b1;
                            pi_d    = 3'd1;
                            pj_d    = 3'd0;
                        end else begin
                            state_d        = DONE;
                            done_d         = 1'b1;
                            onehot_error_d = 1'b1;
                        end
                    end
                end
            end
            CHECK: begin
                if (conflict) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (pi_q == 3'd7 && pj_q == 3'd6) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    legal_d   = 1'b1;
                    count_inc = 1'b1;
                end else if (pj_q == pi_q - 3'd1) begin
                    pi_d = pi_q + 3'd1;
                    pj_d = 3'd0;
                end else begin
                    pj_d = pj_q + 3'd1;
                end
            end
            DONE: begin
                state_d     = RECV;
                row_ready_d = 1'b1;
            end
            default: begin
                state_d     = RECV;
                row_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase

        count_d = count_q;
        if (bus.clear_count) begin
            count_d = '0;
        end else if (count_inc && count_q != '1) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RECV;
            for (int k = 0; k < 8; k++) rows_q[k] <= 8'd0;
            idx_q          <= 3'd0;
            pi_q           <= 3'd1;
            pj_q           <= 3'd0;
            row_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            legal_q        <= 1'b0;
            onehot_error_q <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            for (int k = 0; k < 8; k++) rows_q[k] <= rows_d[k];
            idx_q          <= idx_d;
            pi_q           <= pi_d;
            pj_q           <= pj_d;
            row_ready_q    <= row_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            legal_q        <= legal_d;
            onehot_error_q <= onehot_error_d;
            count_q        <= count_d;
        end
    end

    assign bus.row_ready      = row_ready_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.legal          = legal_q;
    assign bus.onehot_error   = onehot_error_q;
    assign bus.solution_count = count_q;
endmodule

// File: tb/tb_queen_board_checker.sv
// Bench for queen_board_checker: fixed board table, hand sequences for reset/clear/saturation, random boards vs a rule model.
module tb_queen_board_checker;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    queen_board_checker_if #(.COUNT_WIDTH(7)) if7 ();
    queen_board_checker_if #(.COUNT_WIDTH(2)) if2 ();

    queen_board_checker #(.COUNT_WIDTH(7)) dut  (.clk(clk), .reset(reset), .bus(if7));
    queen_board_checker #(.COUNT_WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    int checks = 0;
    int errors = 0;
    int mcount7 = 0;
    int mcount2 = 0;

    localparam logic [63:0] LEGAL_B = 64'h08_02_40_04_20_80_10_01;

    typedef struct {
        logic [63:0] rows;
        int          gap;
        int          exp_lat;
        bit          exp_legal;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit clr);
        if7.row_valid = v;   if2.row_valid = v;
        if7.in_bus = d;      if2.in_bus = d;
        if7.clear_count = clr; if2.clear_count = clr;
    endtask

    // Reference: popcount screen, then the 28 pairs in order; latency counted from the row-7 edge.
    task automatic ref_board(input logic [63:0] b, output int lat, output bit lg, output bit err);
        int col [8];
        logic [7:0] r;
        int k;
        err = 0;
        for (int i = 0; i < 8; i++) begin
            r = b[8*i +: 8];
            if ($countones(r) != 1) err = 1;
            col[i] = 0;
            for (int c = 0; c < 8; c++) if (r[c]) col[i] = c;
        end
        lg = 0;
        if (err) begin
            lat = 1;
            return;
        end
        k = 0;
        for (int i = 1; i < 8; i++) begin
            for (int j = 0; j < i; j++) begin
                int dc;
                k++;
                dc = (col[i] > col[j]) ? col[i] - col[j] : col[j] - col[i];
                if (col[i] == col[j] || dc == i - j) begin
                    lat = k + 1;
                    return;
                end
            end
        end
        lat = 29;
        lg = 1;
    endtask

    task automatic send_rows(input logic [63:0] b, input int gap);
        for (int r = 0; r < 8; r++) begin
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 8'($urandom), 1'b0);
                @(negedge clk);
            end
            drive(1'b1, b[8*r +: 8], 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 8'd0, 1'b0);
    endtask

    task automatic run_board(input logic [63:0] b, input int gap, input bit clr, input bit noise,
                             input int exp_lat, input bit exp_legal, input bit exp_err);
        int n = 1;
        int busy_cnt = 0;
        int rr_bad = 0;
        bit got = 0;
        send_rows(b, gap);
        while (n <= 40) begin
            if (if7.done) begin
                got = 1;
                break;
            end
            if (if7.busy) busy_cnt++;
            if (if7.row_ready) rr_bad++;
            drive(noise ? 1'($urandom) : 1'b0, 8'($urandom), clr && (n == exp_lat - 1));
            @(negedge clk);
            drive(1'b0, 8'd0, 1'b0);
            n++;
        end
        if (clr) begin
            mcount7 = 0;
            mcount2 = 0;
        end else if (exp_legal) begin
            if (mcount7 < 127) mcount7++;
            if (mcount2 < 3) mcount2++;
        end
        chk("done_latency", got ? n : -1, exp_lat);
        chk("legal", int'(if7.legal), int'(exp_legal));
        chk("onehot_error", int'(if7.onehot_error), int'(exp_err));
        chk("solution_count", int'(if7.solution_count), mcount7);
        chk("solution_count_w2", int'(if2.solution_count), mcount2);
        chk("busy_cycles", busy_cnt, exp_lat - 1);
        chk("row_ready_low_while_checking", rr_bad, 0);
        chk("done_row_ready_low", int'(if7.row_ready), 0);
        @(negedge clk);
        chk("done_one_cycle", int'(if7.done), 0);
        chk("row_ready_after_done", int'(if7.row_ready), 1);
        chk("legal_idle_zero", int'(if7.legal), 0);
    endtask

    function automatic logic [63:0] mirror_cols(input logic [63:0] b);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[(i/8)*8 + 7 - (i%8)] = b[i];
        return o;
    endfunction

    function automatic logic [63:0] flip_rows(input logic [63:0] b);
        logic [63:0] o;
        for (int i = 0; i < 8; i++) o[8*(7-i) +: 8] = b[8*i +: 8];
        return o;
    endfunction

    vec_t tbl [8];

    initial begin
        tbl[0] = '{LEGAL_B,                 0, 29, 1, 0};
        tbl[1] = '{64'h0101010101010101,    0,  2, 0, 0};
        tbl[2] = '{64'h02_08_40_04_20_80_10_01, 0, 19, 0, 0};
        tbl[3] = '{64'h02_02_40_04_20_80_10_01, 0, 26, 0, 0};
        tbl[4] = '{64'h08_02_40_04_00_80_10_01, 0,  1, 0, 1};
        tbl[5] = '{64'h08_02_40_04_03_80_10_01, 1,  1, 0, 1};
        tbl[6] = '{64'h00_02_40_04_20_80_10_01, 0,  1, 0, 1};
        tbl[7] = '{LEGAL_B,                 2, 29, 1, 0};

        reset = 1'b1;
        drive(1'b0, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_row_ready", int'(if7.row_ready), 1);
        chk("reset_busy", int'(if7.busy), 0);
        chk("reset_done", int'(if7.done), 0);
        chk("reset_count", int'(if7.solution_count), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_row_ready", int'(if7.row_ready), 1);

        foreach (tbl[t]) begin
            run_board(tbl[t].rows, tbl[t].gap, 1'b0, 1'b0,
                      tbl[t].exp_lat, tbl[t].exp_legal, tbl[t].exp_err);
        end

        // Clear while idle takes effect on the next edge.
        drive(1'b0, 8'd0, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'd0, 1'b0);
        mcount7 = 0;
        mcount2 = 0;
        chk("idle_clear", int'(if7.solution_count), 0);

        run_board(LEGAL_B, 0, 1'b0, 1'b0, 29, 1, 0);
        run_board(LEGAL_B, 0, 1'b0, 1'b0, 29, 1, 0);
        chk("two_boards_count", int'(if7.solution_count), 2);
        run_board(LEGAL_B, 0, 1'b1, 1'b0, 29, 1, 0);
        chk("clear_wins_count", int'(if7.solution_count), 0);
        for (int i = 0; i < 5; i++) run_board(mirror_cols(LEGAL_B), 1, 1'b0, 1'b1, 29, 1, 0);
        chk("count_after_five", int'(if7.solution_count), 5);
        chk("count_w2_saturated", int'(if2.solution_count), 3);

        // Reset ten cycles into the check phase.
        send_rows(LEGAL_B, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        mcount7 = 0;
        mcount2 = 0;
        chk("midcheck_reset_row_ready", int'(if7.row_ready), 1);
        chk("midcheck_reset_busy", int'(if7.busy), 0);
        chk("midcheck_reset_done", int'(if7.done), 0);
        chk("midcheck_reset_legal", int'(if7.legal), 0);
        chk("midcheck_reset_err", int'(if7.onehot_error), 0);
        chk("midcheck_reset_count", int'(if7.solution_count), 0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int dones = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (if7.done || if7.busy) dones++;
            end
            chk("no_done_after_reset", dones, 0);
        end
        run_board(LEGAL_B, 2, 1'b0, 1'b0, 29, 1, 0);
        chk("count_after_reset_board", int'(if7.solution_count), 1);

        for (int it = 0; it < 24; it++) begin
            logic [63:0] b;
            int lat;
            bit lg, err, clr;
            case ($urandom_range(0, 3))
                0: begin
                    b = LEGAL_B;
                    if ($urandom % 2) b = mirror_cols(b);
                    if ($urandom % 2) b = flip_rows(b);
                end
                1: begin
                    for (int i = 0; i < 8; i++) b[8*i +: 8] = 8'($urandom);
                end
                default: begin
                    int perm [8];
                    for (int i = 0; i < 8; i++) perm[i] = i;
                    for (int i = 7; i > 0; i--) begin
                        int j = $urandom_range(0, i);
                        int tmp = perm[i];
                        perm[i] = perm[j];
                        perm[j] = tmp;
                    end
                    for (int i = 0; i < 8; i++) b[8*i +: 8] = 8'(1 << perm[i]);
                end
            endcase
            ref_board(b, lat, lg, err);
            clr = lg && ($urandom % 3 == 0);
            run_board(b, $urandom_range(0, 2), clr, 1'($urandom), lat, lg, err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
